uart_regs: RTL and testbench

//  16550-compatible host register file; sits directly upstream of uart_top.

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_irq_ctrl.sv | 63 ++++++
 rtl/uart_regs.sv | 203 ++++++++++++++++++++
 tb/tb_uart_regs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 16550-style host register file: offsets, IIR ids,
// LSR/IER bit positions and the LCR layout.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_RBR_THR = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_IER     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IIR_FCR = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_LCR     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_MCR     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_LSR     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_MSR     = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_SCR     = 3'd7;

    localparam logic [2:0] IIR_ID_NONE = 3'b000;
    localparam logic [2:0] IIR_ID_THRE = 3'b001;
    localparam logic [2:0] IIR_ID_RX   = 3'b010;
    localparam logic [2:0] IIR_ID_LS   = 3'b011;

    localparam int unsigned LSR_DR   = 0;
    localparam int unsigned LSR_OE   = 1;
    localparam int unsigned LSR_PE   = 2;
    localparam int unsigned LSR_FE   = 3;
    localparam int unsigned LSR_BI   = 4;
    localparam int unsigned LSR_THRE = 5;
    localparam int unsigned LSR_TEMT = 6;
    localparam int unsigned LSR_ERR  = 7;

    localparam int unsigned IER_ERBFI = 0;
    localparam int unsigned IER_ETBEI = 1;
    localparam int unsigned IER_ELSI  = 2;

    typedef struct packed {
        logic       dlab;
        logic       brk;
        logic       par_stick;
        logic       even;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    localparam logic [DATA_W-1:0] LCR_RESET = 8'h03;

    // Two stop bits become 1.5 (2'b11) when the word length is 5 bits.
    function automatic logic [1:0] stop_bits_f(input lcr_t l);
        if (!l.stb) return 2'b01;
        return (l.wls == 2'b00) ? 2'b11 : 2'b10;
    endfunction

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt side of the register file: THRE-empty tracking, IIR priority
// encoding and the registered irq level.
module uart_irq_ctrl
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ier_en,
    input  logic       rx_ready,
    input  logic       tx_ready,
    input  logic       ls_any,
    input  logic       thr_wr,
    input  logic       etbei_set,
    input  logic       iir_rd,
    output logic [7:0] iir_c,
    output logic       irq
);

    logic       tx_ready_q, tx_ready_d;
    logic       thre_q, thre_d;
    logic       irq_q, irq_d;
    logic [2:0] id_c;
    logic       pend_c;
    logic       ls_pend, rx_pend, thre_pend;

    // Fixed priority: line status > rx data > THR empty.
    always_comb begin
        ls_pend   = ier_en[IER_ELSI]  & ls_any;
        rx_pend   = ier_en[IER_ERBFI] & rx_ready;
        thre_pend = ier_en[IER_ETBEI] & thre_q;
        id_c      = IIR_ID_NONE;
        if (ls_pend)        id_c = IIR_ID_LS;
        else if (rx_pend)   id_c = IIR_ID_RX;
        else if (thre_pend) id_c = IIR_ID_THRE;
        pend_c = ls_pend | rx_pend | thre_pend;
    end

    assign iir_c = {2'b11, 2'b00, id_c, ~pend_c};

    // Reading IIR only acknowledges THRE when THRE is what the host saw.
    always_comb begin
        thre_d     = thre_q;
        tx_ready_d = tx_ready;
        irq_d      = pend_c;
        if (thr_wr | (iir_rd & (id_c == IIR_ID_THRE))) thre_d = 1'b0;
        if ((tx_ready & ~tx_ready_q) | etbei_set)      thre_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ready_q <= 1'b0;
            thre_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready_d;
            thre_q     <= thre_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/uart_regs.sv
// 16550-compatible host register file feeding uart_top: bus decode, line and
// baud configuration, FIFO handshakes, sticky line-status errors and irq.
module uart_regs
    import uart_pkg::*;
#(
    parameter int unsigned DL_WIDTH  = 16,
    parameter int unsigned PSD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_en,
    input  logic                 bus_we,
    input  logic [2:0]           bus_addr,
    input  logic [7:0]           bus_wdata,
    output logic [7:0]           bus_rdata,
    output logic                 irq,
    output logic                 wr_en,
    output logic [7:0]           wr_data,
    input  logic                 tx_ready,
    output logic                 rd_en,
    input  logic [7:0]           rd_data,
    input  logic                 rx_ready,
    input  logic                 parity_err,
    input  logic                 framing_err,
    input  logic                 overrun_err,
    output logic [1:0]           stop_bits,
    output logic                 parity_en,
    output logic                 parity_even,
    output logic [3:0]           data_bits,
    output logic [DL_WIDTH-1:0]  divisor_latch,
    output logic [PSD_WIDTH-1:0] psd,
    output logic                 new_baud
);

    lcr_t                 lcr_q, lcr_d;
    logic [3:0]           ier_q, ier_d;
    logic [4:0]           mcr_q, mcr_d;
    logic [7:0]           scr_q, scr_d;
    logic [7:0]           dll_q, dll_d;
    logic [7:0]           dlm_q, dlm_d;
    logic [PSD_WIDTH-1:0] psd_q, psd_d;
    logic                 oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 new_baud_q, new_baud_d;
    logic                 started_q, started_d;

    logic       rd_acc, wr_acc, dlab;
    logic       thr_wr, rbr_rd, lsr_rd, iir_rd, etbei_set, dl_wr;
    logic       ls_any_c;
    logic [7:0] lsr_c;
    logic [7:0] iir_c;

    // Access decode; DLAB remaps offsets 0, 1 and 5 onto the baud registers.
    always_comb begin
        rd_acc    = bus_en & ~bus_we;
        wr_acc    = bus_en & bus_we;
        dlab      = lcr_q.dlab;
        thr_wr    = wr_acc & (bus_addr == ADDR_RBR_THR) & ~dlab;
        rbr_rd    = rd_acc & (bus_addr == ADDR_RBR_THR) & ~dlab;
        lsr_rd    = rd_acc & (bus_addr == ADDR_LSR) & ~dlab;
        iir_rd    = rd_acc & (bus_addr == ADDR_IIR_FCR);
        etbei_set = wr_acc & (bus_addr == ADDR_IER) & ~dlab & bus_wdata[IER_ETBEI]
                    & ~ier_q[IER_ETBEI] & tx_ready;
        dl_wr     = wr_acc & dlab & ((bus_addr == ADDR_RBR_THR) | (bus_addr == ADDR_IER)
                    | (bus_addr == ADDR_LSR));
    end

    assign rd_en = rbr_rd & rx_ready;

    always_comb begin
        ls_any_c        = oe_q | pe_q | fe_q;
        lsr_c           = '0;
        lsr_c[LSR_DR]   = rx_ready;
        lsr_c[LSR_OE]   = oe_q;
        lsr_c[LSR_PE]   = pe_q;
        lsr_c[LSR_FE]   = fe_q;
        lsr_c[LSR_BI]   = 1'b0;
        lsr_c[LSR_THRE] = tx_ready;
        lsr_c[LSR_TEMT] = tx_ready;
        lsr_c[LSR_ERR]  = ls_any_c;
    end

    uart_irq_ctrl u_irq_ctrl (
        .clk      (clk),
        .rst      (rst),
        .ier_en   (ier_q[2:0]),
        .rx_ready (rx_ready),
        .tx_ready (tx_ready),
        .ls_any   (ls_any_c),
        .thr_wr   (thr_wr),
        .etbei_set(etbei_set),
        .iir_rd   (iir_rd),
        .iir_c    (iir_c),
        .irq      (irq)
    );

    // Register writes, read mux and the one-shot output pulses.
    always_comb begin
        lcr_d      = lcr_q;
        ier_d      = ier_q;
        mcr_d      = mcr_q;
        scr_d      = scr_q;
        dll_d      = dll_q;
        dlm_d      = dlm_q;
        psd_d      = psd_q;
        rdata_d    = rdata_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        started_d  = 1'b1;
        new_baud_d = ~started_q | dl_wr;

        // An error pulse coinciding with the LSR read survives the clear.
        oe_d = (lsr_rd ? 1'b0 : oe_q) | overrun_err;
        pe_d = (lsr_rd ? 1'b0 : pe_q) | parity_err;
        fe_d = (lsr_rd ? 1'b0 : fe_q) | framing_err;

        if (wr_acc) begin
            case (bus_addr)
                ADDR_RBR_THR: begin
                    if (dlab) begin
                        dll_d = bus_wdata;
                    end else if (tx_ready) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus_wdata;
                    end
                end
                ADDR_IER: begin
                    if (dlab) dlm_d = bus_wdata;
                    else      ier_d = bus_wdata[3:0];
                end
                ADDR_LCR: lcr_d = lcr_t'(bus_wdata);
                ADDR_MCR: mcr_d = bus_wdata[4:0];
                ADDR_LSR: if (dlab) psd_d = PSD_WIDTH'(bus_wdata);
                ADDR_SCR: scr_d = bus_wdata;
                default: ;
            endcase
        end

        if (rd_acc) begin
            case (bus_addr)
                ADDR_RBR_THR: rdata_d = dlab ? dll_q : (rx_ready ? rd_data : 8'h00);
                ADDR_IER:     rdata_d = dlab ? dlm_q : {4'h0, ier_q};
                ADDR_IIR_FCR: rdata_d = iir_c;
                ADDR_LCR:     rdata_d = 8'(lcr_q);
                ADDR_MCR:     rdata_d = {3'b000, mcr_q};
                ADDR_LSR:     rdata_d = dlab ? 8'(psd_q) : lsr_c;
                ADDR_MSR:     rdata_d = 8'h00;
                ADDR_SCR:     rdata_d = scr_q;
                default:      rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcr_q      <= lcr_t'(LCR_RESET);
            ier_q      <= '0;
            mcr_q      <= '0;
            scr_q      <= '0;
            dll_q      <= 8'h01;
            dlm_q      <= 8'h00;
            psd_q      <= '0;
            oe_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            rdata_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            new_baud_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            lcr_q      <= lcr_d;
            ier_q      <= ier_d;
            mcr_q      <= mcr_d;
            scr_q      <= scr_d;
            dll_q      <= dll_d;
            dlm_q      <= dlm_d;
            psd_q      <= psd_d;
            oe_q       <= oe_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            rdata_q    <= rdata_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            new_baud_q <= new_baud_d;
            started_q  <= started_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign new_baud      = new_baud_q;
    assign divisor_latch = DL_WIDTH'({dlm_q, dll_q});
    assign psd           = psd_q;
    assign data_bits     = 4'd5 + 4'(lcr_q.wls);
    assign stop_bits     = stop_bits_f(lcr_q);
    assign parity_en     = lcr_q.pen;
    assign parity_even   = lcr_q.even;

endmodule

// File: tb/tb_uart_regs.sv
// Self-checking bench for uart_regs: directed register scenarios, a mid-access
// reset and a randomized phase, all checked against a register-level model.
module tb_uart_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_en, bus_we;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        irq, wr_en, rd_en;
    logic [7:0]  wr_data, rd_data;
    logic        tx_ready, rx_ready;
    logic        parity_err, framing_err, overrun_err;
    logic [1:0]  stop_bits;
    logic        parity_en, parity_even;
    logic [3:0]  data_bits;
    logic [15:0] divisor_latch;
    logic [3:0]  psd;
    logic        new_baud;

    int checks   = 0;
    int failures = 0;

    uart_regs #(.DL_WIDTH(16), .PSD_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq), .wr_en(wr_en),
        .wr_data(wr_data), .tx_ready(tx_ready), .rd_en(rd_en), .rd_data(rd_data),
        .rx_ready(rx_ready), .parity_err(parity_err), .framing_err(framing_err),
        .overrun_err(overrun_err), .stop_bits(stop_bits), .parity_en(parity_en),
        .parity_even(parity_even), .data_bits(data_bits), .divisor_latch(divisor_latch),
        .psd(psd), .new_baud(new_baud)
    );

    always #5 clk = ~clk;

    // Register-level model state
    logic [7:0] m_lcr, m_dll, m_dlm, m_scr;
    logic [3:0] m_ier, m_psd;
    logic [4:0] m_mcr;
    logic       m_oe, m_pe, m_fe, m_thre, m_txp, m_started;
    logic       e_wr_en, e_new_baud, e_irq, last_rd_en;
    logic [7:0] e_wr_data, e_rdata;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] m_id();
        if (m_ier[2] && (m_oe || m_pe || m_fe)) return 3'b011;
        if (m_ier[0] && rx_ready)               return 3'b010;
        if (m_ier[1] && m_thre)                 return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic       dl;
        logic [2:0] id;
        dl = m_lcr[7];
        id = m_id();
        case (a)
            3'd0: return dl ? m_dll : (rx_ready ? rd_data : 8'h00);
            3'd1: return dl ? m_dlm : {4'h0, m_ier};
            3'd2: return {4'hC, id, (id == 3'b000)};
            3'd3: return m_lcr;
            3'd4: return {3'b000, m_mcr};
            3'd5: return dl ? {4'h0, m_psd}
                            : {(m_oe | m_pe | m_fe), tx_ready, tx_ready, 1'b0, m_fe, m_pe, m_oe, rx_ready};
            3'd6: return 8'h00;
            default: return m_scr;
        endcase
    endfunction

    task automatic model_reset();
        m_lcr = 8'h03; m_dll = 8'h01; m_dlm = 8'h00; m_scr = 8'h00;
        m_ier = 4'h0; m_psd = 4'h0; m_mcr = 5'h0;
        m_oe = 0; m_pe = 0; m_fe = 0; m_thre = 0; m_txp = 0; m_started = 0;
        e_wr_data = 8'h00; e_rdata = 8'h00;
    endtask

    // One clock: predict the edge's effect from current inputs, then check outputs.
    task automatic tick();
        logic       rd, wr, dl, n_wr_en, n_nb, n_irq, clr_thre, set_thre, lsr_clr;
        logic [2:0] a;
        logic [7:0] d;
        #1;
        rd = bus_en & ~bus_we;
        wr = bus_en & bus_we;
        a  = bus_addr;
        d  = bus_wdata;
        dl = m_lcr[7];
        last_rd_en = rd_en;
        chk("rd_en", 16'(rd_en), 16'(rd && a == 3'd0 && !dl && rx_ready));

        n_irq    = (m_id() != 3'b000);
        if (rd) e_rdata = m_read(a);
        n_wr_en  = wr && a == 3'd0 && !dl && tx_ready;
        if (n_wr_en) e_wr_data = d;
        n_nb     = !m_started || (wr && dl && (a == 3'd0 || a == 3'd1 || a == 3'd5));
        clr_thre = (wr && a == 3'd0 && !dl) || (rd && a == 3'd2 && m_id() == 3'b001);
        set_thre = (tx_ready && !m_txp) || (wr && a == 3'd1 && !dl && d[1] && !m_ier[1] && tx_ready);
        lsr_clr  = rd && a == 3'd5 && !dl;

        if (clr_thre) m_thre = 0;
        if (set_thre) m_thre = 1;
        if (lsr_clr) begin m_oe = 0; m_pe = 0; m_fe = 0; end
        m_oe = m_oe | overrun_err;
        m_pe = m_pe | parity_err;
        m_fe = m_fe | framing_err;
        if (wr) begin
            case (a)
                3'd0: if (dl) m_dll = d;
                3'd1: if (dl) m_dlm = d; else m_ier = d[3:0];
                3'd3: m_lcr = d;
                3'd4: m_mcr = d[4:0];
                3'd5: if (dl) m_psd = d[3:0];
                3'd7: m_scr = d;
                default: ;
            endcase
        end
        m_txp = tx_ready;
        m_started = 1;
        e_wr_en = n_wr_en; e_new_baud = n_nb; e_irq = n_irq;

        @(posedge clk); #1;
        chk("wr_en", 16'(wr_en), 16'(e_wr_en));
        if (e_wr_en) chk("wr_data", 16'(wr_data), 16'(e_wr_data));
        chk("new_baud", 16'(new_baud), 16'(e_new_baud));
        chk("irq", 16'(irq), 16'(e_irq));
        chk("divisor_latch", divisor_latch, {m_dlm, m_dll});
        chk("psd", 16'(psd), 16'(m_psd));
        chk("data_bits", 16'(data_bits), 16'(5 + m_lcr[1:0]));
        chk("stop_bits", 16'(stop_bits),
            16'(!m_lcr[2] ? 2'b01 : (m_lcr[1:0] == 2'b00 ? 2'b11 : 2'b10)));
        chk("parity_en", 16'(parity_en), 16'(m_lcr[3]));
        chk("parity_even", 16'(parity_even), 16'(m_lcr[4]));
        if (rd) chk("bus_rdata", 16'(bus_rdata), 16'(e_rdata));
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        bus_en = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
        tick();
        bus_en = 0; bus_we = 0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        bus_en = 1; bus_we = 0; bus_addr = a;
        tick();
        d = bus_rdata;
        bus_en = 0;
    endtask

    logic [7:0] v;
    int         nb_cnt;

    initial begin
        rst = 1; bus_en = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
        tx_ready = 0; rx_ready = 0; rd_data = 0;
        parity_err = 0; framing_err = 0; overrun_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", 16'(bus_rdata), 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_wr_en", 16'(wr_en), 16'h0);
        chk("rst_wr_data", 16'(wr_data), 16'h0);
        chk("rst_new_baud", 16'(new_baud), 16'h0);
        chk("rst_divisor", divisor_latch, 16'h0001);
        @(negedge clk) rst = 0;
        tick();
        chk("post_rst_new_baud", 16'(new_baud), 16'h1);
        tick();
        chk("new_baud_drop", 16'(new_baud), 16'h0);

        tx_ready = 1;
        tick();
        bus_rd(3'd3, v); chk("lcr_reset", 16'(v), 16'h03);
        bus_rd(3'd2, v); chk("iir_reset", 16'(v), 16'hC1);

        // Baud configuration through DLAB
        bus_wr(3'd3, 8'h80);
        bus_rd(3'd0, v); chk("dll_reset", 16'(v), 16'h01);
        nb_cnt = 0;
        bus_wr(3'd0, 8'h0C); nb_cnt += int'(new_baud);
        bus_wr(3'd1, 8'h00); nb_cnt += int'(new_baud);
        bus_wr(3'd5, 8'h03); nb_cnt += int'(new_baud);
        chk("new_baud_count", 16'(nb_cnt), 16'd3);
        chk("divisor_0c", divisor_latch, 16'h000C);
        chk("psd_3", 16'(psd), 16'h3);
        bus_rd(3'd5, v); chk("psd_read", 16'(v), 16'h03);
        bus_wr(3'd3, 8'h1F);
        chk("lcr1f_bits", 16'(data_bits), 16'd8);
        chk("lcr1f_stop", 16'(stop_bits), 16'h2);
        chk("lcr1f_pen", 16'(parity_en), 16'h1);
        chk("lcr1f_even", 16'(parity_even), 16'h1);

        // TX FIFO push
        bus_wr(3'd0, 8'h5A);
        chk("thr_wr_en", 16'(wr_en), 16'h1);
        chk("thr_wr_data", 16'(wr_data), 16'h5A);
        tick();
        chk("thr_wr_en_drop", 16'(wr_en), 16'h0);
        tx_ready = 0;
        bus_wr(3'd0, 8'h33);
        chk("thr_full_drop", 16'(wr_en), 16'h0);

        // RX FIFO pop
        rx_ready = 1; rd_data = 8'hA5;
        bus_rd(3'd0, v);
        chk("rbr_rd_en", 16'(last_rd_en), 16'h1);
        chk("rbr_data", 16'(v), 16'hA5);
        rx_ready = 0;
        bus_rd(3'd0, v);
        chk("rbr_empty_rd_en", 16'(last_rd_en), 16'h0);
        chk("rbr_empty_data", 16'(v), 16'h00);

        // Line status interrupt and sticky FE
        tx_ready = 1;
        tick();
        bus_wr(3'd1, 8'h07);
        rx_ready = 1;
        framing_err = 1; tick(); framing_err = 0;
        bus_rd(3'd2, v); chk("iir_ls", 16'(v), 16'hC6);
        bus_rd(3'd5, v); chk("lsr_fe", 16'(v), 16'hE9);
        bus_rd(3'd2, v); chk("iir_rx", 16'(v), 16'hC4);
        framing_err = 1; bus_rd(3'd5, v); framing_err = 0;
        chk("lsr_clean", 16'(v), 16'h61);
        bus_rd(3'd5, v); chk("lsr_fe_kept", 16'(v), 16'hE9);
        bus_rd(3'd2, v); chk("iir_rx_again", 16'(v), 16'hC4);

        // THRE interrupt and its acknowledge via IIR read
        rx_ready = 0;
        bus_wr(3'd1, 8'h02);
        tick();
        chk("thre_irq", 16'(irq), 16'h1);
        bus_rd(3'd2, v); chk("iir_thre", 16'(v), 16'hC2);
        tick();
        chk("thre_irq_drop", 16'(irq), 16'h0);
        bus_rd(3'd2, v); chk("iir_none", 16'(v), 16'hC1);

        // Reset in the middle of a THR write
        bus_en = 1; bus_we = 1; bus_addr = 3'd0; bus_wdata = 8'h77;
        #2 rst = 1; tx_ready = 0;
        @(posedge clk); #1;
        bus_en = 0; bus_we = 0;
        chk("midrst_wr_en", 16'(wr_en), 16'h0);
        chk("midrst_new_baud", 16'(new_baud), 16'h0);
        chk("midrst_divisor", divisor_latch, 16'h0001);
        model_reset();
        @(negedge clk) rst = 0;
        tick();
        bus_rd(3'd3, v); chk("midrst_lcr", 16'(v), 16'h03);

        // Randomized traffic; tx_ready only moves on cycles without a bus access
        for (int i = 0; i < 600; i++) begin
            int op;
            rx_ready    = 1'($urandom_range(0, 1));
            rd_data     = 8'($urandom);
            parity_err  = ($urandom_range(0, 9) == 0);
            framing_err = ($urandom_range(0, 9) == 0);
            overrun_err = ($urandom_range(0, 9) == 0);
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                if ($urandom_range(0, 2) == 0) tx_ready = ~tx_ready;
                tick();
            end else if (op == 1) begin
                bus_wr(3'($urandom), 8'($urandom));
            end else begin
                bus_rd(3'($urandom), v);
            end
        end
        parity_err = 0; framing_err = 0; overrun_err = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
